// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side bus arbiter: FSM encoding, port IDs
// and default timing parameters.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Port identifiers; also used as the round-robin "last grant" value.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int NUM_PORTS       = 2;
  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_TO_W    = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on a tie the
// port that did not win last time is chosen.
module rr_arbiter2
  import cpu_bus_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  // Pure combinational grant decision
  always_comb begin
    o_valid = i_req_i | i_req_d;
    o_grant = PORT_I;
    if (i_req_i && i_req_d) begin
      o_grant = ~i_last_grant;
    end else if (i_req_d) begin
      o_grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one IoTop-style slave bus between the instruction-fetch port (I,
// read-only) and the data port (D). One transaction at a time, strobes held
// until RDY or timeout, registered per-port ACK/RDATA/ERR.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = DEFAULT_TO_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDATA,
  output logic        I_ERR,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        D_ERR,
  output logic [31:0] B_ADDR,
  output logic [31:0] B_DIN,
  output logic        B_WE,
  output logic        B_RREQ,
  input  logic [31:0] B_DOUT,
  input  logic        B_RDY,
  output logic        BUSY
);

  state_t            r_state;
  logic              r_grant;
  logic              r_last_grant;
  logic [TO_W-1:0]   r_cnt;
  logic [31:0]       r_b_addr;
  logic [31:0]       r_b_din;
  logic              r_b_we;
  logic              r_b_rreq;
  logic              r_busy;
  logic              r_is_read;
  logic [31:0]       r_cap_data;
  logic              r_cap_err;

  logic              w_arb_valid;
  logic              w_arb_grant;
  logic              w_sel_we;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_din;
  logic              w_ack_any;

  logic [NUM_PORTS-1:0] w_ack;
  logic [NUM_PORTS-1:0] w_err;
  logic [31:0]          w_rdata [NUM_PORTS];

  rr_arbiter2 u_arb (
    .i_req_i      (I_REQ),
    .i_req_d      (D_REQ),
    .i_last_grant (r_last_grant),
    .o_valid      (w_arb_valid),
    .o_grant      (w_arb_grant)
  );

  // Winner's request fields; the fetch port never writes
  assign w_sel_we   = (w_arb_grant == PORT_D) && D_WE;
  assign w_sel_addr = (w_arb_grant == PORT_D) ? D_ADDR : I_ADDR;
  assign w_sel_din  = (w_arb_grant == PORT_D) ? D_WDATA : 32'h0;

  // A requester still sees its ACK this cycle, so its REQ is stale; skip it
  assign w_ack_any = |w_ack;

  // Transaction sequencer: grant, hold strobes until RDY/timeout, complete
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_grant      <= PORT_I;
      r_last_grant <= PORT_D;
      r_cnt        <= '0;
      r_b_addr     <= '0;
      r_b_din      <= '0;
      r_b_we       <= 1'b0;
      r_b_rreq     <= 1'b0;
      r_busy       <= 1'b0;
      r_is_read    <= 1'b0;
      r_cap_data   <= '0;
      r_cap_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid && !w_ack_any) begin
            r_grant   <= w_arb_grant;
            r_b_addr  <= w_sel_addr;
            r_b_din   <= w_sel_din;
            r_b_we    <= w_sel_we;
            r_b_rreq  <= ~w_sel_we;
            r_is_read <= ~w_sel_we;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          // RDY takes priority over an expiring timeout in the same cycle
          if (B_RDY) begin
            r_b_we     <= 1'b0;
            r_b_rreq   <= 1'b0;
            r_cap_data <= B_DOUT;
            r_cap_err  <= 1'b0;
            r_state    <= ST_DONE;
          end else if (r_cnt == TO_W'(TIMEOUT)) begin
            r_b_we     <= 1'b0;
            r_b_rreq   <= 1'b0;
            r_cap_data <= '0;
            r_cap_err  <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        ST_DONE: begin
          r_last_grant <= r_grant;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-port completion registers; the ACK pulse follows the DONE cycle
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    localparam logic MY_PORT = 1'(gi);

    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;

    // Pulse ACK and publish result when this port's transaction finishes
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_ack   <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= '0;
      end else if (r_state == ST_DONE && r_grant == MY_PORT) begin
        r_ack <= 1'b1;
        r_err <= r_cap_err;
        // Stores leave the read-data register untouched
        if (r_is_read) begin
          r_rdata <= r_cap_data;
        end
      end else begin
        r_ack <= 1'b0;
      end
    end

    assign w_ack[gi]   = r_ack;
    assign w_err[gi]   = r_err;
    assign w_rdata[gi] = r_rdata;
  end

  assign I_ACK   = w_ack[PORT_I];
  assign I_ERR   = w_err[PORT_I];
  assign I_RDATA = w_rdata[PORT_I];
  assign D_ACK   = w_ack[PORT_D];
  assign D_ERR   = w_err[PORT_D];
  assign D_RDATA = w_rdata[PORT_D];

  assign B_ADDR  = r_b_addr;
  assign B_DIN   = r_b_din;
  assign B_WE    = r_b_we;
  assign B_RREQ  = r_b_rreq;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter: slave memory model,
// requester tasks with a reference data model, and an arbitration monitor.
module tb_mem_bus_arbiter;

  logic        CLK;
  logic        RST;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_ACK;
  logic [31:0] I_RDATA;
  logic        I_ERR;
  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_ACK;
  logic [31:0] D_RDATA;
  logic        D_ERR;
  logic [31:0] B_ADDR;
  logic [31:0] B_DIN;
  logic        B_WE;
  logic        B_RREQ;
  logic [31:0] B_DOUT;
  logic        B_RDY;
  logic        BUSY;

  mem_bus_arbiter #(.TIMEOUT(255), .TO_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
    .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_WE(B_WE), .B_RREQ(B_RREQ),
    .B_DOUT(B_DOUT), .B_RDY(B_RDY), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Background contents of any address not yet written
  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // ---------------- slave model ----------------
  logic [31:0] mem [logic [31:0]];
  bit slave_hang  = 0;
  bit rand_delay  = 0;
  int slave_delay = 0;
  int cur_delay   = -1;

  initial begin
    B_RDY  = 1'b0;
    B_DOUT = 32'h0;
    forever begin
      @(posedge CLK); #1;
      B_RDY = 1'b0;
      if (RST && (B_WE || B_RREQ) && !slave_hang) begin
        if (cur_delay < 0) cur_delay = rand_delay ? int'($urandom_range(0, 3)) : slave_delay;
        if (cur_delay == 0) begin
          B_RDY = 1'b1;
          if (B_RREQ) B_DOUT = mem.exists(B_ADDR) ? mem[B_ADDR] : fill(B_ADDR);
          else        mem[B_ADDR] = B_DIN;
          cur_delay = -1;
        end else begin
          cur_delay--;
        end
      end else if (!(B_WE || B_RREQ)) begin
        cur_delay = -1;
      end
    end
  end

  // ---------------- arbitration monitor ----------------
  // Addresses with bit 31 set belong to the D port in this bench.
  logic grant_log [$];
  bit   mon_log   = 0;
  logic prev_strb = 1'b0;
  logic prev_ireq = 1'b0;
  logic prev_dreq = 1'b0;
  logic last_win  = 1'b1;
  logic win;

  initial begin
    forever begin
      @(posedge CLK); #2;
      if (!RST) begin
        last_win  = 1'b1;
        prev_strb = 1'b0;
      end else begin
        if (B_WE || B_RREQ) check_eq("onehot", {31'b0, B_WE & B_RREQ}, 32'h0);
        if ((B_WE || B_RREQ) && !prev_strb) begin
          win = B_ADDR[31];
          // Both ports were waiting: the winner must alternate
          if (win ? prev_ireq : prev_dreq)
            check_eq("rr_alternate", {31'b0, win}, {31'b0, ~last_win});
          if (mon_log) grant_log.push_back(win);
          last_win = win;
        end
        prev_strb = B_WE || B_RREQ;
      end
      prev_ireq = I_REQ;
      prev_dreq = D_REQ;
    end
  end

  // ---------------- reference model for D data ----------------
  logic [31:0] d_ref [16];
  logic [31:0] d_rdata_model = 32'h0;

  // Fetch: called at #1 after an edge; exp_lat/exp_strb < 0 disables timing checks
  task automatic do_i(input logic [31:0] addr, input logic [31:0] exp_data,
                      input logic exp_err, input int exp_lat, input int exp_strb);
    int lat = 0;
    int strb = 0;
    bit got = 0;
    I_REQ = 1'b1;
    I_ADDR = addr;
    while (!got && lat < 400) begin
      @(posedge CLK); #1;
      lat++;
      if (I_ACK) got = 1;
      else if (exp_strb >= 0 && (B_WE || B_RREQ)) begin
        strb++;
        check_eq("i_bus_addr", B_ADDR, addr);
        check_eq("i_bus_we", {31'b0, B_WE}, 32'h0);
      end
    end
    I_REQ = 1'b0;
    check_eq("i_ack", {31'b0, I_ACK}, 32'h1);
    if (got) begin
      check_eq("i_rdata", I_RDATA, exp_data);
      check_eq("i_err", {31'b0, I_ERR}, {31'b0, exp_err});
      if (exp_lat >= 0) check_eq("i_latency", lat, exp_lat);
      if (exp_strb >= 0) check_eq("i_strobe_cycles", strb, exp_strb);
    end
    $display("I  rd addr=%h data=%h err=%0d lat=%0d", addr, I_RDATA, I_ERR, lat);
    @(posedge CLK); #1;
    check_eq("i_ack_pulse", {31'b0, I_ACK}, 32'h0);
  endtask

  // Load/store on D; expected data comes from the bench-side reference array
  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input int exp_lat, input int exp_strb);
    logic [31:0] exp_data;
    int lat = 0;
    int strb = 0;
    bit got = 0;
    if (we)           exp_data = d_rdata_model;
    else if (exp_err) exp_data = 32'h0;
    else              exp_data = d_ref[addr[5:2]];
    D_REQ = 1'b1;
    D_WE = we;
    D_ADDR = addr;
    D_WDATA = wdata;
    while (!got && lat < 400) begin
      @(posedge CLK); #1;
      lat++;
      if (D_ACK) got = 1;
      else if (exp_strb >= 0 && (B_WE || B_RREQ)) begin
        strb++;
        check_eq("d_bus_addr", B_ADDR, addr);
        check_eq("d_bus_we", {31'b0, B_WE}, {31'b0, we});
        check_eq("d_bus_rreq", {31'b0, B_RREQ}, {31'b0, ~we});
        if (we) check_eq("d_bus_din", B_DIN, wdata);
      end
    end
    D_REQ = 1'b0;
    check_eq("d_ack", {31'b0, D_ACK}, 32'h1);
    if (got) begin
      check_eq(we ? "d_rdata_store" : "d_rdata_load", D_RDATA, exp_data);
      check_eq("d_err", {31'b0, D_ERR}, {31'b0, exp_err});
      if (exp_lat >= 0) check_eq("d_latency", lat, exp_lat);
      if (exp_strb >= 0) check_eq("d_strobe_cycles", strb, exp_strb);
    end
    if (we && !exp_err) d_ref[addr[5:2]] = wdata;
    if (!we) d_rdata_model = exp_data;
    $display("D  %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
             we ? "wr" : "rd", addr, wdata, D_RDATA, D_ERR, lat);
    @(posedge CLK); #1;
    check_eq("d_ack_pulse", {31'b0, D_ACK}, 32'h0);
  endtask

  function automatic logic [31:0] d_addr(input int idx);
    return 32'h8000_0000 | (32'(idx) << 2);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    RST = 1'b0;
    I_REQ = 1'b0; I_ADDR = 32'h0;
    D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 32'h0; D_WDATA = 32'h0;
    for (int k = 0; k < 16; k++) d_ref[k] = fill(d_addr(k));
    mem[32'h0000_0010] = 32'h0050_0093;

    repeat (3) begin @(posedge CLK); end
    #1;
    check_eq("rst_i_ack",   {31'b0, I_ACK}, 32'h0);
    check_eq("rst_d_ack",   {31'b0, D_ACK}, 32'h0);
    check_eq("rst_i_err",   {31'b0, I_ERR}, 32'h0);
    check_eq("rst_d_err",   {31'b0, D_ERR}, 32'h0);
    check_eq("rst_i_rdata", I_RDATA, 32'h0);
    check_eq("rst_d_rdata", D_RDATA, 32'h0);
    check_eq("rst_b_addr",  B_ADDR, 32'h0);
    check_eq("rst_b_din",   B_DIN, 32'h0);
    check_eq("rst_b_we",    {31'b0, B_WE}, 32'h0);
    check_eq("rst_b_rreq",  {31'b0, B_RREQ}, 32'h0);
    check_eq("rst_busy",    {31'b0, BUSY}, 32'h0);
    RST = 1'b1;

    // Single fetch, RDY one cycle after strobe rises
    slave_delay = 1;
    do_i(32'h0000_0010, 32'h0050_0093, 1'b0, 4, 2);

    // Load, store, load back: store must not disturb D_RDATA
    slave_delay = 0;
    do_d(1'b0, d_addr(3), 32'h0, 1'b0, 3, 1);
    do_d(1'b1, d_addr(0), 32'h0000_00A5, 1'b0, 3, 1);
    do_d(1'b0, d_addr(0), 32'h0, 1'b0, 3, 1);

    // Wait states: RDY 5 cycles late, ACK two cycles after RDY
    slave_delay = 5;
    do_i(32'h0000_0200, fill(32'h0000_0200), 1'b0, 8, 6);

    // Timeout: 256 BUS cycles then ERR; next request normal
    slave_hang = 1;
    do_d(1'b0, d_addr(2), 32'h0, 1'b1, 258, 256);
    slave_hang = 0;
    slave_delay = 0;
    do_d(1'b0, d_addr(2), 32'h0, 1'b0, 3, 1);

    // Reset while the bus is waiting on the slave
    slave_hang = 1;
    I_REQ = 1'b1;
    I_ADDR = 32'h0000_0300;
    repeat (4) begin @(posedge CLK); #1; end
    check_eq("mid_busy", {31'b0, BUSY}, 32'h1);
    check_eq("mid_rreq", {31'b0, B_RREQ}, 32'h1);
    #2;
    RST = 1'b0;
    #1;
    check_eq("async_rreq", {31'b0, B_RREQ}, 32'h0);
    check_eq("async_we",   {31'b0, B_WE}, 32'h0);
    check_eq("async_busy", {31'b0, BUSY}, 32'h0);
    I_REQ = 1'b0;
    repeat (3) begin
      @(posedge CLK); #1;
      check_eq("rst_no_ack", {31'b0, I_ACK}, 32'h0);
    end
    slave_hang = 0;
    d_rdata_model = 32'h0;
    RST = 1'b1;
    do_i(32'h0000_0300, fill(32'h0000_0300), 1'b0, 3, 1);

    // Contention from reset: expect I, D, I, D
    RST = 1'b0;
    @(posedge CLK); #1;
    d_rdata_model = 32'h0;
    grant_log.delete();
    mon_log = 1;
    slave_delay = 2;
    RST = 1'b1;
    fork
      begin
        do_i(32'h0000_0400, fill(32'h0000_0400), 1'b0, -1, -1);
        do_i(32'h0000_0404, fill(32'h0000_0404), 1'b0, -1, -1);
      end
      begin
        do_d(1'b0, d_addr(5), 32'h0, 1'b0, -1, -1);
        do_d(1'b1, d_addr(6), 32'h1234_ABCD, 1'b0, -1, -1);
      end
    join
    mon_log = 0;
    check_eq("order_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check_eq($sformatf("order%0d", k), {31'b0, grant_log[k]}, 32'(k % 2));

    // Randomized concurrent traffic with random slave wait states
    rand_delay = 1;
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          int gap;
          int r;
          gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge CLK); #1; end
          r = int'($urandom_range(64, 1023));
          do_i(32'(r) << 2, fill(32'(r) << 2), 1'b0, -1, -1);
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          int gap;
          int idx;
          logic we;
          gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge CLK); #1; end
          idx = int'($urandom_range(0, 15));
          we = 1'($urandom_range(0, 1));
          do_d(we, d_addr(idx), $urandom, 1'b0, -1, -1);
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global safety net in case a bounded wait is somehow bypassed
  initial begin
    #500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory-mapped I/O/memory slave bus between two CPU requesters: the instruction-fetch port (I, read-only) and the data load/store port (D).
- The slave bus uses the IoTop-style signal set: ADDR, DIN, WE, RREQ, DOUT, RDY.
- Arbitrates round-robin, sequences one transaction at a time, and holds the slave strobes until RDY.
- Returns a registered ACK per port, plus an error flag on timeout.

Parameters:
- TIMEOUT, 255: max cycles waiting for B_RDY before aborting the transaction with ERR.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset (asserted when 0).
- I_REQ  in  1  fetch request; held high with I_ADDR until I_ACK.
- I_ADDR  in  32  fetch address.
- I_ACK  out  1  one-cycle pulse: the fetch transaction completed.
- I_RDATA  out  32  fetch data; valid in the I_ACK cycle, held until the next I completion.
- I_ERR  out  1  valid with I_ACK; 1 = timeout.
- D_REQ  in  1  data request; held high with D_WE/D_ADDR/D_WDATA until D_ACK.
- D_WE  in  1  1 = store, 0 = load.
- D_ADDR  in  32  data address.
- D_WDATA  in  32  store data.
- D_ACK  out  1  one-cycle pulse: the data transaction completed.
- D_RDATA  out  32  load data; valid in the D_ACK cycle; unchanged by stores.
- D_ERR  out  1  valid with D_ACK; 1 = timeout.
- B_ADDR  out  32  slave address.
- B_DIN  out  32  slave write data.
- B_WE  out  1  slave write strobe (level, held until RDY).
- B_RREQ  out  1  slave read strobe (level, held until RDY).
- B_DOUT  in  32  slave read data; sampled in the B_RDY cycle.
- B_RDY  in  1  slave completion; ignored when no strobe is active.
- BUSY  out  1  1 when FSM is not IDLE.

Behaviour:
- Reset (RST=0, async):
  - FSM state: IDLE.
  - All outputs 0; B_ADDR/B_DIN = 0.
  - last_grant = D, so I wins the first tie.
  - Timeout counter = 0.
  - Reset mid-transaction aborts it silently; no ACK is issued.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - If exactly one REQ is high, grant that port.
  - If both are high, grant the port not equal to last_grant.
  - Register the winner's ADDR/WDATA/WE onto B_*.
  - Set B_WE=D_WE for D, or B_RREQ=1 for a D load or any I request (I never writes).
  - Go to BUS; counter = 0.
- BUS:
  - B_* held stable.
  - If B_RDY=1: deassert strobes; capture B_DOUT into the granted port's RDATA (reads only); ERR=0; go to DONE.
  - Else if counter == TIMEOUT: deassert strobes; RDATA = 0; ERR=1; go to DONE.
  - Else counter += 1.
- DONE (one cycle):
  - Pulse the granted port's ACK.
  - last_grant = granted port.
  - Return to IDLE.
- Latency: REQ seen at edge 0 → strobe visible after edge 1 → RDY at cycle k → ACK high in cycle k+2 (after edge k+1). Zero-wait slave (RDY in first BUS cycle): ACK 3 cycles after REQ.
- Each requester must deassert REQ or present a new request in the cycle after ACK. IDLE does not re-sample a REQ in the same cycle ACK is high, which prevents double issue.
- B_RDY in IDLE/DONE is ignored.
- B_RDY in the same cycle as counter == TIMEOUT: RDY wins, ERR=0.
- Only one strobe is ever high; B_WE and B_RREQ are never both 1.
- Address/data wrap: none. The 32-bit value is passed unmodified.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - FSM state encoding (IDLE=2'd0, BUS=2'd1, DONE=2'd2).
  - Port ID constants PORT_I=1'b0, PORT_D=1'b1.
  - Default TIMEOUT.
- One natural sub-module: rr_arbiter2 — combinational 2-way round-robin grant from {I_REQ, D_REQ, last_grant}.
- FSM, timeout counter and datapath muxing stay in the top module.

Test Plan:
- Single fetch: I_REQ=1, I_ADDR=0x00000010; slave returns B_DOUT=0x00500093 with RDY one cycle after B_RREQ rises → I_ACK pulse, I_RDATA=0x00500093, I_ERR=0, B_WE never 1.
- Store then load: D store to 0x80000000, WDATA=0x000000A5 → B_WE=1, B_DIN=0xA5 until RDY. Then a D load of the same address with slave DOUT=0xA5 → D_RDATA=0x000000A5; D_RDATA unchanged across the store's D_ACK.
- Contention: I_REQ and D_REQ both held high from reset, each request re-issued after its ACK → grant order I, D, I, D for 4 transactions; no port is starved.
- Wait states: slave delays RDY 5 cycles → B_ADDR/B_RREQ stable for all 5; ACK exactly 2 cycles after RDY.
- Timeout: slave never asserts RDY, TIMEOUT=255 → strobe drops after 256 BUS cycles; D_ACK=1, D_ERR=1, D_RDATA=0; next request proceeds normally.
- Reset mid-operation: pull RST low while in BUS → B_RREQ/B_WE drop immediately (async), no ACK. After release, a fresh I request completes normally.
